// File: rtl/tfe_pkg.sv
// -----------------------------------------------------------------------------
// tfe_pkg
// Shared definitions for the tuple extractor that feeds the TFE hashing stage:
// tuple width, EtherType / IP protocol constants, the capture FSM state type
// and a helper that packs the 104-bit tuple in its canonical field order.
// -----------------------------------------------------------------------------
package tfe_pkg;

   localparam int          TUPLE_W    = 104;
   localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETYPE_VLAN = 16'h8100;
   localparam logic [7:0]  PROTO_TCP  = 8'd6;
   localparam logic [7:0]  PROTO_UDP  = 8'd17;

   // Capture FSM. Evaluation is a one-cycle pipeline flag rather than a
   // state, so a new frame can start in the same cycle a frame is evaluated.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2
   } fsm_state_t;

   // Packs {ip_a, ip_b, port_a, port_b, proto}. Forward tuple uses
   // (src,dst,sport,dport); reverse tuple uses (dst,src,dport,sport).
   function automatic logic [TUPLE_W-1:0] pack_tuple(
      input logic [31:0] ip_a,
      input logic [31:0] ip_b,
      input logic [15:0] port_a,
      input logic [15:0] port_b,
      input logic [7:0]  proto
   );
      return {ip_a, ip_b, port_a, port_b, proto};
   endfunction

endpackage

// File: rtl/tuple_field_mux.sv
// -----------------------------------------------------------------------------
// tuple_field_mux
// Combinational byte extractor. Given the captured header bytes and the number
// of valid bytes, locates the IPv4 header (with or without one 802.1Q tag),
// validates it and produces the forward and reverse 5-tuples.
// Ports:
//   i_buf      captured header beats, byte 0 in the MSBs (network order)
//   i_len      number of valid bytes in i_buf
//   o_tuple    {src_ip, dst_ip, src_port, dst_port, proto}
//   o_r_tuple  {dst_ip, src_ip, dst_port, src_port, proto}
//   o_ok       frame is IPv4 with a sane header and enough captured bytes
// -----------------------------------------------------------------------------
module tuple_field_mux
   import tfe_pkg::*;
#(
   parameter int HDR_BEATS = 11,
   parameter int LEN_W     = 7
) (
   input  logic [HDR_BEATS*64-1:0] i_buf,
   input  logic [LEN_W-1:0]        i_len,
   output logic [TUPLE_W-1:0]      o_tuple,
   output logic [TUPLE_W-1:0]      o_r_tuple,
   output logic                    o_ok
);

   localparam int HDR_BYTES = HDR_BEATS * 8;
   // Byte offsets reach at most 18 + 60 + 3 = 81; comparisons run at 8 bits.
   localparam int CMP_W = 8;

   logic [7:0]       w_b [0:HDR_BYTES-1];
   logic [15:0]      w_etype_outer;
   logic [15:0]      w_etype;
   logic [6:0]       w_l3;
   logic [6:0]       w_l4;
   logic [7:0]       w_vihl;
   logic [7:0]       w_proto;
   logic [12:0]      w_frag;
   logic [31:0]      w_src_ip;
   logic [31:0]      w_dst_ip;
   logic [15:0]      w_src_port;
   logic [15:0]      w_dst_port;
   logic             w_l3_ok;
   logic             w_has_ports;
   logic [CMP_W-1:0] w_len_c;

   // Split the flat buffer into network-order bytes.
   always_comb begin
      for (int k = 0; k < HDR_BYTES; k++) begin
         w_b[k] = i_buf[(HDR_BYTES-1-k)*8 +: 8];
      end
   end

   // Header walk: locate L3/L4, validate, and select the port fields.
   always_comb begin
      w_etype_outer = {w_b[12], w_b[13]};
      w_len_c       = CMP_W'(i_len);
      if (w_etype_outer == ETYPE_VLAN) begin
         w_l3    = 7'd18;
         w_etype = {w_b[16], w_b[17]};
      end else begin
         w_l3    = 7'd14;
         w_etype = w_etype_outer;
      end

      w_vihl   = w_b[w_l3];
      w_proto  = w_b[w_l3 + 7'd9];
      w_frag   = {w_b[w_l3 + 7'd6][4:0], w_b[w_l3 + 7'd7]};
      w_src_ip = {w_b[w_l3 + 7'd12], w_b[w_l3 + 7'd13], w_b[w_l3 + 7'd14], w_b[w_l3 + 7'd15]};
      w_dst_ip = {w_b[w_l3 + 7'd16], w_b[w_l3 + 7'd17], w_b[w_l3 + 7'd18], w_b[w_l3 + 7'd19]};
      // L4 offset = L3 + 4*IHL; IHL is 4 bits so this fits in 7 bits.
      w_l4     = w_l3 + {1'b0, w_vihl[3:0], 2'b00};

      w_l3_ok = (w_etype == ETYPE_IPV4) &&
                (w_vihl[7:4] == 4'd4) &&
                (w_vihl[3:0] >= 4'd5) &&
                (w_len_c >= (CMP_W'(w_l3) + 8'd20));

      // Only first fragments of TCP/UDP carry the port header.
      w_has_ports = ((w_proto == PROTO_TCP) || (w_proto == PROTO_UDP)) &&
                    (w_frag == 13'd0);

      if (w_has_ports) begin
         w_src_port = {w_b[w_l4], w_b[w_l4 + 7'd1]};
         w_dst_port = {w_b[w_l4 + 7'd2], w_b[w_l4 + 7'd3]};
         o_ok       = w_l3_ok && (w_len_c >= (CMP_W'(w_l4) + 8'd4));
      end else begin
         w_src_port = 16'h0000;
         w_dst_port = 16'h0000;
         o_ok       = w_l3_ok;
      end

      o_tuple   = pack_tuple(w_src_ip, w_dst_ip, w_src_port, w_dst_port, w_proto);
      o_r_tuple = pack_tuple(w_dst_ip, w_src_ip, w_dst_port, w_src_port, w_proto);
   end

endmodule

// File: rtl/tuple_extractor.sv
// -----------------------------------------------------------------------------
// tuple_extractor
// Captures the first HDR_BEATS beats of each frame of a 64-bit stream, then in
// a one-cycle evaluation stage extracts the IPv4 5-tuple and its reverse and
// presents them with a one-cycle valid pulse. Never back-pressures.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_data/s_valid       frame beat (byte 0 in [63:56]) and its qualifier
//   s_sop/s_eop/s_empty  frame delimiters, trailing empty bytes on eop beat
//   ip_tuple/r_ip_tuple  forward / reverse tuple, held between pulses
//   ip_tuple_v           one-cycle pulse, tuples updated
//   cnt_tuple/cnt_drop   wrapping counts of good / dropped frames
// -----------------------------------------------------------------------------
module tuple_extractor
   import tfe_pkg::*;
#(
   parameter int HDR_BEATS = 11,
   parameter int CNT_W     = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [63:0]        s_data,
   input  logic               s_valid,
   input  logic               s_sop,
   input  logic               s_eop,
   input  logic [2:0]         s_empty,
   output logic [TUPLE_W-1:0] ip_tuple,
   output logic [TUPLE_W-1:0] r_ip_tuple,
   output logic               ip_tuple_v,
   output logic [CNT_W-1:0]   cnt_tuple,
   output logic [CNT_W-1:0]   cnt_drop
);

   localparam int LEN_W  = $clog2(HDR_BEATS*8 + 1);
   localparam int BCNT_W = $clog2(HDR_BEATS + 1);

   fsm_state_t                r_state;
   logic [BCNT_W-1:0]         r_bcnt;
   logic                      r_eval;
   logic [LEN_W-1:0]          r_len;
   logic [63:0]               r_buf [0:HDR_BEATS-1];

   logic                      w_sop_beat;
   logic                      w_abort;
   logic [BCNT_W-1:0]         w_bcnt_inc;
   logic [LEN_W-1:0]          w_len_first;
   logic [LEN_W-1:0]          w_len_eop;
   logic                      w_wr_en;
   logic [BCNT_W-1:0]         w_wr_idx;
   logic [HDR_BEATS*64-1:0]   w_buf_flat;
   logic [TUPLE_W-1:0]        w_tuple;
   logic [TUPLE_W-1:0]        w_r_tuple;
   logic                      w_ok;
   logic [1:0]                w_drop_inc;

   // Beat classification and frame-length arithmetic for the trigger beat.
   always_comb begin
      w_sop_beat  = s_valid & s_sop;
      // A sop while still capturing means the previous frame lost its eop.
      w_abort     = w_sop_beat & (r_state == ST_CAPTURE);
      w_bcnt_inc  = r_bcnt + BCNT_W'(1'b1);
      w_len_first = LEN_W'(4'd8) - LEN_W'(s_empty);
      w_len_eop   = LEN_W'({w_bcnt_inc, 3'b000}) - LEN_W'(s_empty);
   end

   // Buffer write port: sop always lands in slot 0, capture fills in order.
   always_comb begin
      if (w_sop_beat) begin
         w_wr_en  = 1'b1;
         w_wr_idx = '0;
      end else if (s_valid && (r_state == ST_CAPTURE)) begin
         w_wr_en  = 1'b1;
         w_wr_idx = r_bcnt;
      end else begin
         w_wr_en  = 1'b0;
         w_wr_idx = '0;
      end
   end

   // Header buffer storage; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_buf[w_wr_idx] <= s_data;
      end
   end

   // Flatten the buffer for the extractor, beat 0 in the MSBs.
   always_comb begin
      w_buf_flat = '0;
      for (int k = 0; k < HDR_BEATS; k++) begin
         w_buf_flat[(HDR_BEATS-1-k)*64 +: 64] = r_buf[k];
      end
   end

   // Capture FSM with the registered evaluation strobe and frame length.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_bcnt  <= '0;
         r_eval  <= 1'b0;
         r_len   <= '0;
      end else begin
         r_eval <= 1'b0;
         case (r_state)
            ST_IDLE, ST_DRAIN: begin
               if (w_sop_beat) begin
                  if (s_eop) begin
                     r_eval  <= 1'b1;
                     r_len   <= w_len_first;
                     r_bcnt  <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_bcnt  <= BCNT_W'(1'b1);
                     r_state <= ST_CAPTURE;
                  end
               end else if (s_valid && s_eop && (r_state == ST_DRAIN)) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= r_state;
               end
            end
            ST_CAPTURE: begin
               if (w_sop_beat) begin
                  if (s_eop) begin
                     r_eval  <= 1'b1;
                     r_len   <= w_len_first;
                     r_bcnt  <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_bcnt  <= BCNT_W'(1'b1);
                     r_state <= ST_CAPTURE;
                  end
               end else if (s_valid) begin
                  if (s_eop) begin
                     r_eval  <= 1'b1;
                     r_len   <= w_len_eop;
                     r_bcnt  <= '0;
                     r_state <= ST_IDLE;
                  end else if (w_bcnt_inc == BCNT_W'(HDR_BEATS)) begin
                     // Header window full: evaluate now, discard the rest.
                     r_eval  <= 1'b1;
                     r_len   <= LEN_W'(HDR_BEATS*8);
                     r_bcnt  <= '0;
                     r_state <= ST_DRAIN;
                  end else begin
                     r_bcnt  <= w_bcnt_inc;
                  end
               end else begin
                  r_state <= ST_CAPTURE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_bcnt  <= '0;
            end
         endcase
      end
   end

   tuple_field_mux #(
      .HDR_BEATS (HDR_BEATS),
      .LEN_W     (LEN_W)
   ) u_field_mux (
      .i_buf     (w_buf_flat),
      .i_len     (r_len),
      .o_tuple   (w_tuple),
      .o_r_tuple (w_r_tuple),
      .o_ok      (w_ok)
   );

   // Abort and a bad evaluation are counted independently.
   always_comb begin
      w_drop_inc = {1'b0, r_eval & ~w_ok} + {1'b0, w_abort};
   end

   // Output registers and statistics counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ip_tuple   <= '0;
         r_ip_tuple <= '0;
         ip_tuple_v <= 1'b0;
         cnt_tuple  <= '0;
         cnt_drop   <= '0;
      end else begin
         if (r_eval && w_ok) begin
            ip_tuple   <= w_tuple;
            r_ip_tuple <= w_r_tuple;
            ip_tuple_v <= 1'b1;
            cnt_tuple  <= cnt_tuple + CNT_W'(1'b1);
         end else begin
            ip_tuple_v <= 1'b0;
         end
         cnt_drop <= cnt_drop + CNT_W'(w_drop_inc);
      end
   end

endmodule

// File: tb/tb_tuple_extractor.sv
module tb_tuple_extractor;

   logic         clk;
   logic         rst_n;
   logic [63:0]  s_data;
   logic         s_valid;
   logic         s_sop;
   logic         s_eop;
   logic [2:0]   s_empty;
   logic [103:0] ip_tuple;
   logic [103:0] r_ip_tuple;
   logic         ip_tuple_v;
   logic [31:0]  cnt_tuple;
   logic [31:0]  cnt_drop;

   tuple_extractor #(.HDR_BEATS(11), .CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_sop      (s_sop),
      .s_eop      (s_eop),
      .s_empty    (s_empty),
      .ip_tuple   (ip_tuple),
      .r_ip_tuple (r_ip_tuple),
      .ip_tuple_v (ip_tuple_v),
      .cnt_tuple  (cnt_tuple),
      .cnt_drop   (cnt_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int trig_cyc = 0;
   int pulse_cnt = 0;
   int last_pulse_cyc = -1;
   logic [103:0] pulse_q [$];
   logic [7:0]   fr [0:255];

   localparam logic [103:0] T1_FWD = 104'h0a000001_0a000002_04d2_0050_06;
   localparam logic [103:0] T1_REV = 104'h0a000002_0a000001_0050_04d2_06;
   localparam logic [103:0] T2_FWD = 104'hc0a8010a_ac100005_14e9_0035_11;
   localparam logic [103:0] T2_REV = 104'hac100005_c0a8010a_0035_14e9_11;
   localparam logic [103:0] T4_ICMP = 104'h01020304_05060708_0000_0000_01;
   localparam logic [103:0] T4_FRAG = 104'h0a010101_0a020202_0000_0000_11;
   localparam logic [103:0] T4_FRAG_R = 104'h0a020202_0a010101_0000_0000_11;
   localparam logic [103:0] T4_MIN = 104'hc0000201_c0000202_0001_0002_06;

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (ip_tuple_v === 1'b1) begin
         pulse_cnt      <= pulse_cnt + 1;
         last_pulse_cyc <= cyc;
         pulse_q.push_back(ip_tuple);
      end
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic build(input bit vlan, input logic [15:0] etype, input logic [3:0] ver,
                        input logic [3:0] ihl, input logic [15:0] frag, input logic [7:0] proto,
                        input logic [31:0] src, input logic [31:0] dst,
                        input logic [15:0] sp, input logic [15:0] dp);
      int l3;
      int l4;
      for (int i = 0; i < 256; i++) fr[i] = 8'hA5 ^ 8'(i);
      if (vlan) begin
         fr[12] = 8'h81; fr[13] = 8'h00; fr[14] = 8'h00; fr[15] = 8'h05;
         fr[16] = etype[15:8]; fr[17] = etype[7:0];
         l3 = 18;
      end else begin
         fr[12] = etype[15:8]; fr[13] = etype[7:0];
         l3 = 14;
      end
      fr[l3]      = {ver, ihl};
      fr[l3 + 6]  = frag[15:8];
      fr[l3 + 7]  = frag[7:0];
      fr[l3 + 9]  = proto;
      for (int k = 0; k < 4; k++) begin
         fr[l3 + 12 + k] = src[31 - 8*k -: 8];
         fr[l3 + 16 + k] = dst[31 - 8*k -: 8];
      end
      l4 = l3 + 4 * int'(ihl);
      fr[l4]     = sp[15:8];
      fr[l4 + 1] = sp[7:0];
      fr[l4 + 2] = dp[15:8];
      fr[l4 + 3] = dp[7:0];
   endtask

   // Drives ceil(nbytes/8) beats back-to-back; records the cycle of beat trig_beat.
   task automatic send_frame(input int nbytes, input bit do_sop, input bit do_eop, input int trig_beat);
      int nb;
      nb = (nbytes + 7) / 8;
      for (int b = 0; b < nb; b++) begin
         s_valid = 1'b1;
         s_sop   = do_sop && (b == 0);
         s_eop   = do_eop && (b == nb - 1);
         s_empty = (do_eop && (b == nb - 1)) ? 3'(nb * 8 - nbytes) : 3'd0;
         for (int k = 0; k < 8; k++) s_data[63 - 8*k -: 8] = fr[b*8 + k];
         if (b + 1 == trig_beat) trig_cyc = cyc;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
      s_empty = 3'd0;
   endtask

   initial begin
      int p0;
      rst_n   = 1'b0;
      s_data  = 64'd0;
      s_valid = 1'b0;
      s_sop   = 1'b0;
      s_eop   = 1'b0;
      s_empty = 3'd0;
      #23;
      check("rst_tuple",   128'(ip_tuple),   128'(0));
      check("rst_rtuple",  128'(r_ip_tuple), 128'(0));
      check("rst_valid",   128'(ip_tuple_v), 128'(0));
      check("rst_cnt_tup", 128'(cnt_tuple),  128'(0));
      check("rst_cnt_drp", 128'(cnt_drop),   128'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1: untagged TCP, 64 B
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h4000, 8'd6, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80);
      p0 = pulse_cnt;
      send_frame(64, 1'b1, 1'b1, 8);
      check("t1_eval_cycle_quiet", 128'(ip_tuple_v), 128'(0));
      idle(1);
      check("t1_pulse", 128'(ip_tuple_v), 128'(1));
      check("t1_fwd",   128'(ip_tuple),   128'(T1_FWD));
      check("t1_rev",   128'(r_ip_tuple), 128'(T1_REV));
      idle(1);
      check("t1_pulse_end",  128'(ip_tuple_v), 128'(0));
      check("t1_pulse_cnt",  128'(pulse_cnt - p0), 128'(1));
      check("t1_latency",    128'(last_pulse_cyc - trig_cyc), 128'(2));
      check("t1_cnt_tuple",  128'(cnt_tuple), 128'(1));

      // 2: VLAN UDP, IHL=15, 128 B; evaluated at beat 11, rest drained
      build(1'b1, 16'h0800, 4'd4, 4'd15, 16'h0000, 8'd17, 32'hc0a8010a, 32'hac100005, 16'd5353, 16'd53);
      p0 = pulse_cnt;
      send_frame(128, 1'b1, 1'b1, 11);
      idle(2);
      check("t2_pulse_cnt", 128'(pulse_cnt - p0), 128'(1));
      check("t2_latency",   128'(last_pulse_cyc - trig_cyc), 128'(2));
      check("t2_fwd",       128'(ip_tuple),   128'(T2_FWD));
      check("t2_rev",       128'(r_ip_tuple), 128'(T2_REV));
      check("t2_cnt_tuple", 128'(cnt_tuple),  128'(2));

      // 3: ARP, then 30 B truncated IPv4
      p0 = pulse_cnt;
      build(1'b0, 16'h0806, 4'd4, 4'd5, 16'h0000, 8'd17, 32'h01010101, 32'h02020202, 16'd1, 16'd2);
      send_frame(64, 1'b1, 1'b1, 8);
      idle(3);
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h0000, 8'd17, 32'h01010101, 32'h02020202, 16'd1, 16'd2);
      send_frame(30, 1'b1, 1'b1, 4);
      idle(3);
      check("t3_no_pulse",  128'(pulse_cnt - p0), 128'(0));
      check("t3_cnt_drop",  128'(cnt_drop),  128'(2));
      check("t3_cnt_tuple", 128'(cnt_tuple), 128'(2));
      check("t3_fwd_hold",  128'(ip_tuple),   128'(T2_FWD));
      check("t3_rev_hold",  128'(r_ip_tuple), 128'(T2_REV));

      // 4: ICMP, non-first UDP fragment, L4 length boundary, bad IHL
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h0000, 8'd1, 32'h01020304, 32'h05060708, 16'hdead, 16'hbeef);
      send_frame(64, 1'b1, 1'b1, 8);
      idle(3);
      check("t4_icmp_fwd", 128'(ip_tuple), 128'(T4_ICMP));
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h20B9, 8'd17, 32'h0a010101, 32'h0a020202, 16'd1111, 16'd2222);
      send_frame(64, 1'b1, 1'b1, 8);
      idle(3);
      check("t4_frag_fwd", 128'(ip_tuple),   128'(T4_FRAG));
      check("t4_frag_rev", 128'(r_ip_tuple), 128'(T4_FRAG_R));
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h0000, 8'd6, 32'hc0000201, 32'hc0000202, 16'h0001, 16'h0002);
      send_frame(38, 1'b1, 1'b1, 5);
      idle(3);
      check("t4_len38_fwd", 128'(ip_tuple), 128'(T4_MIN));
      check("t4_len38_cnt", 128'(cnt_tuple), 128'(5));
      send_frame(37, 1'b1, 1'b1, 5);
      idle(3);
      check("t4_len37_drop", 128'(cnt_drop), 128'(3));
      build(1'b0, 16'h0800, 4'd4, 4'd4, 16'h0000, 8'd6, 32'h09090909, 32'h08080808, 16'd7, 16'd8);
      send_frame(64, 1'b1, 1'b1, 8);
      idle(3);
      check("t4_ihl4_drop",   128'(cnt_drop),  128'(4));
      check("t4_ihl4_hold",   128'(ip_tuple),  128'(T4_MIN));
      check("t4_cnt_tuple",   128'(cnt_tuple), 128'(5));
      // one-beat frames on consecutive cycles, each too short
      send_frame(8, 1'b1, 1'b1, 1);
      send_frame(8, 1'b1, 1'b1, 1);
      send_frame(8, 1'b1, 1'b1, 1);
      idle(3);
      check("t4_1beat_drop", 128'(cnt_drop), 128'(7));

      // 5: twenty frames back-to-back / 1-beat gaps, plus one aborted frame
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      check("t5_rst_cnt", 128'(cnt_tuple), 128'(0));
      pulse_q.delete();
      for (int i = 0; i < 20; i++) begin
         build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h0000, 8'd6, 32'h0a000001, 32'h0a000002, 16'd1234, 16'(1000 + i));
         send_frame(64, 1'b1, 1'b1, 8);
         if (i == 9) send_frame(24, 1'b1, 1'b0, 0);
         if (i % 2 == 1) idle(1);
      end
      idle(4);
      check("t5_cnt_tuple", 128'(cnt_tuple), 128'(20));
      check("t5_cnt_drop",  128'(cnt_drop),  128'(1));
      check("t5_pulses",    128'(pulse_q.size()), 128'(20));
      for (int i = 0; i < 20 && i < pulse_q.size(); i++) begin
         check($sformatf("t5_dport_%0d", i), 128'(pulse_q[i][23:8]), 128'(1000 + i));
      end

      // 6: reset mid-frame, trailing beats without sop
      build(1'b0, 16'h0800, 4'd4, 4'd5, 16'h4000, 8'd6, 32'h0a000001, 32'h0a000002, 16'd1234, 16'd80);
      send_frame(24, 1'b1, 1'b0, 0);
      rst_n = 1'b0;
      #2;
      check("t6_rst_cnt_tuple", 128'(cnt_tuple), 128'(0));
      check("t6_rst_cnt_drop",  128'(cnt_drop),  128'(0));
      check("t6_rst_fwd",       128'(ip_tuple),  128'(0));
      idle(1);
      rst_n = 1'b1;
      idle(1);
      p0 = pulse_cnt;
      send_frame(64, 1'b0, 1'b1, 8);
      idle(4);
      check("t6_no_pulse",  128'(pulse_cnt - p0), 128'(0));
      check("t6_cnt_tuple", 128'(cnt_tuple),  128'(0));
      check("t6_cnt_drop",  128'(cnt_drop),   128'(0));
      check("t6_fwd_zero",  128'(ip_tuple),   128'(0));
      check("t6_rev_zero",  128'(r_ip_tuple), 128'(0));
      send_frame(64, 1'b1, 1'b1, 8);
      idle(4);
      check("t6_recover_cnt", 128'(cnt_tuple), 128'(1));
      check("t6_recover_fwd", 128'(ip_tuple),  128'(T1_FWD));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
